// File: rtl/circuit4_sched.sv
// circuit4_sched: resource-shared multi-cycle circuit4 with one add/sub unit and one comparator.
// A start in IDLE latches a, b, c; done pulses with registered x, z six edges later.
module circuit4_sched #(
    parameter int DATAWIDTH = 64,
    parameter int OUTWIDTH  = 32
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        start,
    input  logic signed [DATAWIDTH-1:0] a,
    input  logic signed [DATAWIDTH-1:0] b,
    input  logic signed [DATAWIDTH-1:0] c,
    output logic                        busy,
    output logic                        done,
    output logic signed [OUTWIDTH-1:0]  x,
    output logic signed [OUTWIDTH-1:0]  z
);
    typedef enum logic [2:0] {IDLE, CALC_D, CALC_E, CALC_F, COMPARE, SELECT, WRITE} state_t;
    state_t state;
    logic signed [DATAWIDTH-1:0] a_r, b_r, c_r, d, e, f, g, h;
    logic signed [DATAWIDTH-1:0] op_b, alu, g_n, x_n, z_n;
    logic lt, eq;
    // Shared add/sub: second operand and op select come from the state.
    assign op_b = state == CALC_E ? c_r : b_r;
    assign alu  = state == CALC_F ? a_r - op_b : a_r + op_b;
    assign g_n  = lt ? d : e;
    assign x_n  = lt ? h <<< 1 : h;
    assign z_n  = eq ? g >>> 1 : g;
    assign busy = state != IDLE;
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            done  <= 1'b0;
            x     <= '0;
            z     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= '0;
            d     <= '0;
            e     <= '0;
            f     <= '0;
            g     <= '0;
            h     <= '0;
            lt    <= 1'b0;
            eq    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_r   <= a;
                    b_r   <= b;
                    c_r   <= c;
                    state <= CALC_D;
                end
                CALC_D: begin
                    d     <= alu;
                    state <= CALC_E;
                end
                CALC_E: begin
                    e     <= alu;
                    state <= CALC_F;
                end
                CALC_F: begin
                    f     <= alu;
                    state <= COMPARE;
                end
                COMPARE: begin
                    lt    <= d < e;
                    eq    <= d == e;
                    state <= SELECT;
                end
                SELECT: begin
                    g     <= g_n;
                    h     <= eq ? g_n : f;
                    state <= WRITE;
                end
                WRITE: begin
                    x     <= x_n[OUTWIDTH-1:0];
                    z     <= z_n[OUTWIDTH-1:0];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_circuit4_sched.sv
// tb_circuit4_sched: directed table, async-reset sequences and randomized back-to-back
// traffic checked against a cycle-free reference of the circuit4 function.
module tb_circuit4_sched;
    logic               Clk = 1'b0;
    logic               Rst = 1'b0;
    logic               start = 1'b0;
    logic signed [63:0] a = '0, b = '0, c = '0;
    logic               busy, done;
    logic signed [31:0] x, z;
    int vectors = 0;
    int miscompares = 0;

    circuit4_sched #(.DATAWIDTH(64), .OUTWIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b), .c(c),
        .busy(busy), .done(done), .x(x), .z(z)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [63:0] a, b, c;
        logic [31:0] x, z;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] x, z;
    } exp_t;

    function automatic logic [63:0] ref_xz(input logic signed [63:0] ia, ib, ic);
        logic signed [63:0] d, e, f, g, h, xs, zs;
        d  = ia + ib;
        e  = ia + ic;
        f  = ia - ib;
        g  = (d < e) ? d : e;
        h  = (d == e) ? g : f;
        xs = (d < e) ? h * 2 : h;
        zs = (d == e) ? g >>> 1 : g;
        return {xs[31:0], zs[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [63:0] ia, ib, ic,
                          input logic [31:0] ex, ez);
        int lat;
        @(negedge Clk);
        a = ia; b = ib; c = ic; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'd6);
        chk({name, " x"}, {32'd0, x}, {32'd0, ex});
        chk({name, " z"}, {32'd0, z}, {32'd0, ez});
        @(negedge Clk);
        chk({name, " done width"}, {63'd0, done}, 64'd0);
    endtask

    vec_t tbl[4];
    exp_t q[$];
    logic [63:0] r;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{64'd10, 64'd3, 64'd5, 32'd14, 32'd13};
        tbl[1] = '{64'd4, 64'd6, 64'd6, 32'd10, 32'd5};
        tbl[2] = '{64'd0, 64'd9, 64'd2, 32'hFFFFFFF7, 32'd2};
        tbl[3] = '{64'h7FFFFFFFFFFFFFFF, 64'd1, 64'd0, 32'hFFFFFFFC, 32'h0};

        #2;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset xz", {x, z}, 64'd0);
        @(negedge Clk);
        Rst = 1'b1;

        foreach (tbl[i]) begin
            r = ref_xz(tbl[i].a, tbl[i].b, tbl[i].c);
            chk("model vs table", r, {tbl[i].x, tbl[i].z});
            run_op("table", tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].x, tbl[i].z);
        end

        // Asynchronous reset between edges clears outputs immediately.
        run_op("pre-reset", 64'd10, 64'd3, 64'd5, 32'd14, 32'd13);
        #2 Rst = 1'b0;
        #1;
        chk("async busy", {63'd0, busy}, 64'd0);
        chk("async xz", {x, z}, 64'd0);
        @(negedge Clk);
        Rst = 1'b1;

        // Reset pulsed in COMPARE aborts the operation.
        run_op("pre-abort", 64'd4, 64'd6, 64'd6, 32'd10, 32'd5);
        @(negedge Clk);
        a = 64'd10; b = 64'd3; c = 64'd5; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        chk("abort busy", {63'd0, busy}, 64'd0);
        chk("abort xz", {x, z}, 64'd0);
        @(negedge Clk);
        Rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            chk("abort no done", {63'd0, done}, 64'd0);
        end
        chk("abort x held", {x, z}, 64'd0);
        run_op("post-abort", 64'd0, 64'd9, 64'd2, 32'hFFFFFFF7, 32'd2);

        // Random single operations.
        for (int k = 0; k < 20; k++) begin
            logic [63:0] ra, rb, rc;
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            rc = (k % 4 == 0) ? rb : {$urandom, $urandom};
            if (k % 5 == 1) begin
                ra = 64'($signed($urandom_range(40)) - 20);
                rb = 64'($signed($urandom_range(40)) - 20);
                rc = 64'($signed($urandom_range(40)) - 20);
            end
            r = ref_xz(ra, rb, rc);
            run_op("random", ra, rb, rc, r[63:32], r[31:0]);
        end

        // start held high with operands changing every cycle.
        @(negedge Clk);
        begin
            int next_free = 0;
            for (int t = 0; t < 120; t++) begin
                logic exp_done;
                exp_done = q.size() > 0 && q[0].due == t;
                chk("stream done", {63'd0, done}, {63'd0, exp_done});
                if (done && exp_done) begin
                    chk("stream xz", {x, z}, {q[0].x, q[0].z});
                end
                if (exp_done) void'(q.pop_front());
                if (t < 100) begin
                    a = {$urandom, $urandom}; b = {$urandom, $urandom};
                    c = (t % 3 == 0) ? b : {$urandom, $urandom};
                    start = 1'b1;
                    if (t >= next_free) begin
                        r = ref_xz(a, b, c);
                        q.push_back('{t + 7, r[63:32], r[31:0]});
                        next_free = t + 7;
                    end
                end else begin
                    start = 1'b0;
                end
                @(negedge Clk);
            end
            chk("stream drained", 64'(q.size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
